instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of the 24-bit CPU. It owns the program counter and issues word reads to instruction memory over a request/ready handshake. It holds each returned instruction in an instruction register and presents it, with its opcode and funct fields split out, to the decode/control stage through a valid/ready handshake. Branch redirects from execute flush any in-flight or held instruction; a HALT opcode freezes fetch until reset.

## Interface
- ADDR_W, 8: instruction word-address width; the PC wraps modulo 2^ADDR_W.
- RESET_PC, 0: PC value loaded on reset.
- HALT_OP, 4'b1111: opcode that stops fetch.

Ports:
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  word address of the request; equals pc.
- imem_rdata  in  24  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory accepts the request and returns data in the same cycle.
- if_valid  out  1  instr/OPCODE/FUNCT/if_pc hold a valid instruction.
- id_ready  in  1  decode accepts the instruction this cycle.
- instr  out  24  held instruction register.
- OPCODE  out  4  instr[23:20].
- FUNCT  out  4  instr[3:0].
- if_pc  out  ADDR_W  address of the held instruction.
- br_taken  in  1  redirect request from execute.
- br_target  in  ADDR_W  redirect address.
- halted  out  1  HALT has been accepted by decode.
- fetch_count  out  16  number of instructions accepted by decode; wraps at 16 bits.

## Operation
- States: S_FETCH, S_HOLD, S_HALT.
- Reset, on any edge with Reset=1, overriding all other inputs:
  - state=S_FETCH, pc=RESET_PC.
  - instr=0, if_pc=0, fetch_count=0, halted=0.
- S_FETCH:
  - imem_req=1, imem_addr=pc, if_valid=0.
  - If br_taken=1: pc<=br_target, stay in S_FETCH, and discard imem_rdata even if imem_ready=1.
  - Else if imem_ready=1: instr<=imem_rdata, if_pc<=pc, pc<=pc+1 (wrapping), go to S_HOLD.
  - Else: hold.
- S_HOLD:
  - if_valid=1, imem_req=0.
  - If br_taken=1: the held instruction is dropped (not counted), pc<=br_target, go to S_FETCH.
  - Else if id_ready=1: fetch_count<=fetch_count+1. If OPCODE==HALT_OP, go to S_HALT and set halted<=1; otherwise go to S_FETCH.
  - Else: hold instr and if_pc unchanged. This is the stall case.
- S_HALT:
  - imem_req=0, if_valid=0, halted=1.
  - br_taken is ignored. Only Reset exits S_HALT.
- Priority: Reset > br_taken > imem_ready/id_ready.
- OPCODE and FUNCT are combinational slices of instr, so they are stable for the whole S_HOLD residency. The control unit decodes them only while if_valid=1.
- No speculative overlap: at most one instruction is in flight or held at any time.

## Timing
- Minimum fetch-to-fetch period is 2 cycles: S_FETCH with imem_ready=1, then S_HOLD with id_ready=1.
- if_valid rises on the edge after the imem_ready handshake.
- A redirect takes effect on the next edge: imem_addr=br_target in the following S_FETCH cycle.
- imem_req, imem_addr and if_valid are Moore outputs decoded from state and pc only. They have no combinational path from any input.
- halted and fetch_count are registered.
- PC wrap: when pc=2^ADDR_W-1, the next pc is 0. if_pc of that instruction stays 2^ADDR_W-1.
- Reset asserted mid-S_HOLD: the held instruction is lost, and if_valid=0 on the next edge.

## Test plan
- **Reset, then steady fetch.**
  - Stimulus: Reset for 2 cycles; memory always ready, returning 24'h6xx005 at address 0; id_ready=1.
  - Required: imem_addr sequence 0,1,2 on alternating cycles; at address 0, if_valid pulses with OPCODE=6, FUNCT=5, if_pc=0; fetch_count increments once per accept.
- **Memory wait states.**
  - Stimulus: imem_ready low for 3 cycles, then high.
  - Required: imem_req=1 and imem_addr constant for 4 cycles; if_valid=0 throughout; instr is captured only on the ready cycle.
- **Decode stall.**
  - Stimulus: id_ready=0 for 5 cycles while a BEQ (opcode 4) is held.
  - Required: if_valid=1, instr and if_pc stable, imem_req=0, fetch_count unchanged; the count advances by 1 on release.
- **Redirect in both states.**
  - Stimulus: br_taken with br_target=8'h40 (a) in S_FETCH together with imem_ready=1, and (b) in S_HOLD together with id_ready=1.
  - Required: the next imem_addr=8'h40; neither instruction is counted or stored as valid.
- **HALT.**
  - Stimulus: fetch 24'hF00000, accept it, then drive br_taken.
  - Required: halted=1; imem_req stays 0 indefinitely, with br_taken ignored; Reset restores pc=RESET_PC and halted=0.
- **PC wrap.**
  - Stimulus: br_target=8'hFF, then two fetches.
  - Required: addresses FF then 00; if_pc=FF for the first instruction.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads one instruction word at a time and holds it
// for decode. Branch redirects flush the current fetch; HALT freezes fetch until reset.
module instruction_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [23:0]       imem_rdata,
  input  logic              imem_ready,
  output logic              if_valid,
  input  logic              id_ready,
  output logic [23:0]       instr,
  output logic [3:0]        OPCODE,
  output logic [3:0]        FUNCT,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;

  // Handshake outputs depend only on state and pc, never on inputs.
  assign imem_req  = (state == S_FETCH);
  assign if_valid  = (state == S_HOLD);
  assign imem_addr = pc;
  assign OPCODE    = instr[23:20];
  assign FUNCT     = instr[3:0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      if_pc       <= '0;
      fetch_count <= '0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (br_taken) begin
            pc <= br_target;
          end else if (imem_ready) begin
            instr <= imem_rdata;
            if_pc <= pc;
            pc    <= pc + 1'b1;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // A redirect drops the held instruction without counting it.
          if (br_taken) begin
            pc    <= br_target;
            state <= S_FETCH;
          end else if (id_ready) begin
            fetch_count <= fetch_count + 16'd1;
            if (instr[23:20] == HALT_OP) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, steady fetch, wait states,
// decode stall, redirects, PC wrap, HALT and reset out of HOLD.
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [23:0] imem_rdata;
  logic        imem_ready;
  logic        if_valid;
  logic        id_ready;
  logic [23:0] instr;
  logic [3:0]  OPCODE;
  logic [3:0]  FUNCT;
  logic [7:0]  if_pc;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        halted;
  logic [15:0] fetch_count;

  logic [23:0] mem [256];
  int n_chk = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;
  assign imem_rdata = mem[imem_addr];

  instruction_fetch_unit dut (
    .Clock(Clock), .Reset(Reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .if_valid(if_valid), .id_ready(id_ready),
    .instr(instr), .OPCODE(OPCODE), .FUNCT(FUNCT), .if_pc(if_pc),
    .br_taken(br_taken), .br_target(br_target),
    .halted(halted), .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {4'h1, 12'h000, i[7:0]};
    mem[8'h00] = 24'h612005;
    mem[8'h01] = 24'h100001;
    mem[8'h02] = 24'h4AB00C;
    mem[8'h40] = 24'h340007;
    mem[8'h80] = 24'hF00000;
    mem[8'hFF] = 24'h7FF00E;

    Reset = 1'b1; imem_ready = 1'b1; id_ready = 1'b1;
    br_taken = 1'b0; br_target = 8'h00;
    step(); step();
    check("rst_req", imem_req, 1);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_valid", if_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_halted", halted, 0);
    check("rst_count", fetch_count, 0);

    // Steady fetch
    Reset = 1'b0;
    step();
    check("f0_valid", if_valid, 1);
    check("f0_req", imem_req, 0);
    check("f0_opcode", OPCODE, 4'h6);
    check("f0_funct", FUNCT, 4'h5);
    check("f0_pc", if_pc, 8'h00);
    step();
    check("f0_count", fetch_count, 1);
    check("f1_addr", imem_addr, 8'h01);
    check("f1_valid", if_valid, 0);
    step();
    check("f1_instr", instr, 24'h100001);
    step();
    check("f1_count", fetch_count, 2);
    check("f2_addr", imem_addr, 8'h02);

    // Memory wait states, then decode stall on a BEQ
    imem_ready = 1'b0; id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ws_req", imem_req, 1);
      check("ws_addr", imem_addr, 8'h02);
      check("ws_valid", if_valid, 0);
      check("ws_instr", instr, 24'h100001);
    end
    imem_ready = 1'b1;
    step();
    check("ws_capture", instr, 24'h4AB00C);
    for (int i = 0; i < 5; i++) begin
      step();
      check("st_valid", if_valid, 1);
      check("st_instr", instr, 24'h4AB00C);
      check("st_opcode", OPCODE, 4'h4);
      check("st_pc", if_pc, 8'h02);
      check("st_req", imem_req, 0);
      check("st_count", fetch_count, 2);
    end
    id_ready = 1'b1;
    step();
    check("st_release", fetch_count, 3);
    check("st_next_addr", imem_addr, 8'h03);

    // Redirect in FETCH with imem_ready high: data at 3 is discarded
    br_taken = 1'b1; br_target = 8'h40;
    step();
    check("brf_addr", imem_addr, 8'h40);
    check("brf_valid", if_valid, 0);
    check("brf_instr", instr, 24'h4AB00C);
    br_taken = 1'b0;
    step();
    check("brf_fetch", instr, 24'h340007);
    check("brf_pc", if_pc, 8'h40);
    // Redirect in HOLD with id_ready high: not counted
    br_taken = 1'b1;
    step();
    check("brh_addr", imem_addr, 8'h40);
    check("brh_valid", if_valid, 0);
    check("brh_count", fetch_count, 3);

    // PC wrap
    br_target = 8'hFF;
    step();
    check("wr_addr_ff", imem_addr, 8'hFF);
    br_taken = 1'b0;
    step();
    check("wr_pc_ff", if_pc, 8'hFF);
    check("wr_instr", instr, 24'h7FF00E);
    step();
    check("wr_addr_00", imem_addr, 8'h00);
    check("wr_count", fetch_count, 4);
    step();
    check("wr_pc_00", if_pc, 8'h00);
    step();
    check("wr_count2", fetch_count, 5);

    // HALT
    br_taken = 1'b1; br_target = 8'h80;
    step();
    br_taken = 1'b0;
    step();
    check("h_opcode", OPCODE, 4'hF);
    step();
    check("h_halted", halted, 1);
    check("h_count", fetch_count, 6);
    br_taken = 1'b1; br_target = 8'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      check("h_req", imem_req, 0);
      check("h_valid", if_valid, 0);
      check("h_halted_hold", halted, 1);
    end
    br_taken = 1'b0;
    Reset = 1'b1;
    step();
    check("hr_addr", imem_addr, 8'h00);
    check("hr_halted", halted, 0);
    check("hr_req", imem_req, 1);
    check("hr_count", fetch_count, 0);

    // Reset while an instruction is held
    Reset = 1'b0; id_ready = 1'b0;
    step();
    check("rh_valid_pre", if_valid, 1);
    Reset = 1'b1;
    step();
    check("rh_valid", if_valid, 0);
    check("rh_instr", instr, 0);
    check("rh_addr", imem_addr, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
